// File: rtl/dispatch_ctrl_pkg.sv
// Shared types and constants for the dispatch controller: state encoding and
// class-field geometry.
`ifndef DISPATCH_CTRL_PKG_SV
`define DISPATCH_CTRL_PKG_SV

package dispatch_ctrl_pkg;

  localparam int unsigned CLASS_W   = 2;
  localparam int unsigned NUM_CLASS = 4;

  typedef enum logic [2:0] {
    StReset  = 3'd0,
    StInit   = 3'd1,
    StIdle   = 3'd2,
    StActive = 3'd3,
    StError  = 3'd4
  } state_e;

endpackage

// Class field sits in the top CLASS_W bits of a word of width w.
`define DISPATCH_CLASS(data, w) data[(w)-1 -: dispatch_ctrl_pkg::CLASS_W]

`endif

// File: rtl/dispatch_ctrl_fsm.sv
// Dispatch controller state machine: state register, threshold latch and
// validation, and head-of-line stall counter.
module dispatch_ctrl_fsm
  import dispatch_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned STALL_MAX = 64
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             init_i,
  input  logic [CNT_W-1:0] cfg_af_i,
  input  logic [CNT_W-1:0] cfg_ae_i,
  input  logic             in_empty_i,
  input  logic             in_pop_i,
  input  logic             out_valid_i,
  input  logic             fifo_busy_i,
  input  logic             overflow_i,
  output state_e           state_o,
  output logic [CNT_W-1:0] af_o,
  output logic [CNT_W-1:0] ae_o
);

  localparam int unsigned STALL_W = $clog2(STALL_MAX + 1);
  localparam logic [STALL_W-1:0] STALL_C = STALL_W'(STALL_MAX);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   af_q, af_d;
  logic [CNT_W-1:0]   ae_q, ae_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               cfg_ok;

  // Validation runs on the latched thresholds, not on the live cfg inputs.
  assign cfg_ok = (af_q != '0) && ({1'b0, af_q} <= DEPTH_C) && (ae_q < af_q);

  always_comb begin
    state_d = state_q;
    af_d    = af_q;
    ae_d    = ae_q;
    stall_d = '0;
    case (state_q)
      StReset: state_d = StInit;
      StInit: begin
        if (init_i) begin
          af_d = cfg_af_i;
          ae_d = cfg_ae_i;
        end else begin
          state_d = cfg_ok ? StIdle : StError;
        end
      end
      StIdle: begin
        if (init_i) begin
          state_d = StInit;
        end else if (!in_empty_i || fifo_busy_i) begin
          state_d = StActive;
        end
      end
      StActive: begin
        if (init_i) begin
          state_d = StInit;
        end else if (overflow_i) begin
          state_d = StError;
        end else if (!in_empty_i && !in_pop_i) begin
          stall_d = stall_q + 1'b1;
          if (stall_d == STALL_C) begin
            state_d = StError;
          end
        end else if (in_empty_i && !out_valid_i && !fifo_busy_i) begin
          state_d = StIdle;
        end
      end
      StError: state_d = StError;
      default: state_d = StError;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StReset;
      af_q    <= '0;
      ae_q    <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      stall_q <= stall_d;
    end
  end

  assign state_o = state_q;
  assign af_o    = af_q;
  assign ae_o    = ae_q;

endmodule

// File: rtl/dispatch_ctrl.sv
// Flow controller between the input FIFO and the 4-way class demux: pops the
// head word when its class FIFO is below almost-full and registers it out.
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned STALL_MAX = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   init,
  input  logic [CNT_W-1:0]       cfg_af,
  input  logic [CNT_W-1:0]       cfg_ae,
  input  logic                   in_empty,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   in_pop,
  input  logic [4*CNT_W-1:0]     fifo_cnt,
  output logic [DATA_W-1:0]      out_data,
  output logic [1:0]             out_class,
  output logic                   out_valid,
  output logic [CNT_W-1:0]       af_q,
  output logic [CNT_W-1:0]       ae_q,
  output logic [2:0]             state,
  output logic                   idle,
  output logic                   error
);

  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  state_e              st;
  logic [CLASS_W-1:0]  head_cls;
  logic [CNT_W:0]      eff [NUM_CLASS];
  logic                fifo_busy;
  logic                pop_req;
  logic                overflow;

  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [CLASS_W-1:0]  out_class_q, out_class_d;
  logic                out_valid_q, out_valid_d;

  assign head_cls  = `DISPATCH_CLASS(in_data, DATA_W);
  assign fifo_busy = |fifo_cnt;

  // The registered word is not yet counted downstream, so charge it here.
  always_comb begin
    for (int c = 0; c < NUM_CLASS; c++) begin
      eff[c] = {1'b0, fifo_cnt[c*CNT_W +: CNT_W]} +
               {{CNT_W{1'b0}}, (out_valid_q && (out_class_q == CLASS_W'(c)))};
    end
  end

  always_comb begin
    pop_req  = !reset && (st == StActive) && !init && !in_empty &&
               (eff[head_cls] < {1'b0, af_q});
    overflow = pop_req && (eff[head_cls] >= DEPTH_C);
    in_pop   = pop_req && !overflow;
  end

  always_comb begin
    out_valid_d = in_pop;
    out_data_d  = in_pop ? in_data : '0;
    out_class_d = in_pop ? head_cls : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_class_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_class_q <= out_class_d;
    end
  end

  dispatch_ctrl_fsm #(
    .DEPTH     (DEPTH),
    .CNT_W     (CNT_W),
    .STALL_MAX (STALL_MAX)
  ) u_fsm (
    .clk_i       (clk),
    .reset_i     (reset),
    .init_i      (init),
    .cfg_af_i    (cfg_af),
    .cfg_ae_i    (cfg_ae),
    .in_empty_i  (in_empty),
    .in_pop_i    (in_pop),
    .out_valid_i (out_valid_q),
    .fifo_busy_i (fifo_busy),
    .overflow_i  (overflow),
    .state_o     (st),
    .af_o        (af_q),
    .ae_o        (ae_q)
  );

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_class = out_class_q;
  assign state     = st;
  assign idle      = (st == StIdle);
  assign error     = (st == StError);

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl with an upstream FIFO model and an
// output scoreboard fed from the words the DUT pops.
module tb_dispatch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        init;
  logic [3:0]  cfg_af, cfg_ae;
  logic        in_empty;
  logic [11:0] in_data;
  logic        in_pop;
  logic [15:0] fifo_cnt;
  logic [11:0] out_data;
  logic [1:0]  out_class;
  logic        out_valid;
  logic [3:0]  af_q, ae_q;
  logic [2:0]  state;
  logic        idle, error;

  logic [11:0] src[$];
  logic [13:0] sb[$];
  int checks = 0;
  int errors = 0;
  logic pop_seen;

  always #5 clk = ~clk;

  dispatch_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .init      (init),
    .cfg_af    (cfg_af),
    .cfg_ae    (cfg_ae),
    .in_empty  (in_empty),
    .in_data   (in_data),
    .in_pop    (in_pop),
    .fifo_cnt  (fifo_cnt),
    .out_data  (out_data),
    .out_class (out_class),
    .out_valid (out_valid),
    .af_q      (af_q),
    .ae_q      (ae_q),
    .state     (state),
    .idle      (idle),
    .error     (error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic upd_src();
    if (src.size() == 0) begin
      in_empty = 1'b1;
      in_data  = '0;
    end else begin
      in_empty = 1'b0;
      in_data  = src[0];
    end
  endtask

  task automatic set_cnt(input int c, input logic [3:0] v);
    fifo_cnt[c*4 +: 4] = v;
  endtask

  // One clock: sample pop before the edge, then retire the source word and
  // score the registered output just after the edge.
  task automatic tick();
    logic [11:0] w;
    logic [13:0] e;
    logic        exp_v;
    @(negedge clk);
    pop_seen = in_pop;
    if (pop_seen === 1'b1) sb.push_back({in_data[11:10], in_data});
    @(posedge clk);
    #1;
    if (pop_seen === 1'b1) w = src.pop_front();
    upd_src();
    exp_v = (sb.size() != 0);
    chk("out_valid", out_valid, exp_v);
    if (exp_v && out_valid === 1'b1) begin
      e = sb.pop_front();
      chk("out_class", out_class, e[13:12]);
      chk("out_data", out_data, e[11:0]);
    end else begin
      sb.delete();
      chk("out_data_idle", out_data, 0);
    end
  endtask

  task automatic do_init(input logic [3:0] af, input logic [3:0] ae, input logic [2:0] exp_st);
    src.delete();
    upd_src();
    fifo_cnt = '0;
    reset = 1'b1;
    init = 1'b1;
    cfg_af = af;
    cfg_ae = ae;
    tick();
    tick();
    chk("rst_state", state, 0);
    chk("rst_af", af_q, 0);
    chk("rst_ae", ae_q, 0);
    chk("rst_idle", idle, 0);
    chk("rst_error", error, 0);
    chk("rst_pop", in_pop, 0);
    reset = 1'b0;
    tick();
    chk("init_state_a", state, 1);
    tick();
    chk("init_state_b", state, 1);
    init = 1'b0;
    tick();
    chk("cfg_state", state, exp_st);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int max);
    int n = 0;
    while (state !== s && n < max) begin
      tick();
      n++;
    end
    chk(tag, state, s);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   n;
    logic any;
    reset = 1'b1; init = 1'b0; cfg_af = '0; cfg_ae = '0;
    fifo_cnt = '0; in_empty = 1'b1; in_data = '0;

    // Configuration: one valid setting and two invalid ones.
    do_init(4'd6, 4'd2, 3'd2);
    chk("af_latched", af_q, 6);
    chk("ae_latched", ae_q, 2);
    chk("idle_flag", idle, 1);
    chk("no_error", error, 0);
    do_init(4'd9, 4'd2, 3'd4);
    repeat (3) tick();
    chk("af9_sticky", state, 4);
    chk("af9_error", error, 1);
    chk("af9_nopop", in_pop, 0);
    do_init(4'd6, 4'd6, 3'd4);
    repeat (2) tick();
    chk("ae_eq_af_sticky", state, 4);

    // Back-to-back words, one of each class.
    do_init(4'd6, 4'd2, 3'd2);
    src.push_back(12'h012); src.push_back(12'h456);
    src.push_back(12'h89A); src.push_back(12'hCDE);
    upd_src();
    tick();
    chk("b2b_active", state, 3);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("b2b_pop", pop_seen, 1);
    end
    wait_state("b2b_idle", 3'd2, 10);

    // Backpressure on class 1 against af=6.
    set_cnt(1, 4'd5);
    src.push_back(12'h400); src.push_back(12'h401);
    upd_src();
    tick();
    chk("bp_active", state, 3);
    tick();
    chk("bp_first_pop", pop_seen, 1);
    tick();
    chk("bp_inflight_block", pop_seen, 0);
    set_cnt(1, 4'd6);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_full_block", pop_seen, 0);
    end
    set_cnt(1, 4'd4);
    tick();
    chk("bp_resume", pop_seen, 1);
    set_cnt(1, 4'd0);
    wait_state("bp_idle", 3'd2, 10);

    // Head-of-line stall into ERROR.
    set_cnt(2, 4'd8);
    src.push_back(12'h800);
    upd_src();
    tick();
    chk("stall_active", state, 3);
    n = 0;
    any = 1'b0;
    while (state !== 3'd4 && n < 200) begin
      tick();
      any = any | pop_seen;
      n++;
    end
    chk("stall_cycles", n, 64);
    chk("stall_nopop", any, 0);
    chk("stall_error", error, 1);

    // Re-init from ACTIVE with a word in flight, then reset mid-transfer.
    do_init(4'd6, 4'd2, 3'd2);
    src.push_back(12'h123); src.push_back(12'h456);
    upd_src();
    tick();
    tick();
    chk("ri_pop", pop_seen, 1);
    cfg_af = 4'd5;
    cfg_ae = 4'd1;
    init = 1'b1;
    tick();
    chk("ri_nopop", pop_seen, 0);
    chk("ri_init", state, 1);
    tick();
    init = 1'b0;
    tick();
    chk("ri_idle", state, 2);
    chk("ri_af", af_q, 5);
    chk("ri_ae", ae_q, 1);
    tick();
    chk("ri_active", state, 3);
    tick();
    chk("ri_pop2", pop_seen, 1);
    src.push_back(12'h789);
    upd_src();
    reset = 1'b1;
    tick();
    chk("mid_rst_nopop", pop_seen, 0);
    chk("mid_rst_state", state, 0);
    chk("mid_rst_src", src.size(), 1);
    reset = 1'b0;
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
